ysyx_24080006_mdu_iter: RTL

//   Parametrised iterative multiply/divide unit for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/ysyx_24080006_mdu_iter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_mdu_iter.sv
// Iterative RV32M multiply/divide unit.
// The multiplier is a shift-add core that retires MUL_STEP multiplier bits per cycle.
// The divider is a restoring core that produces DIV_STEP quotient bits per cycle, MSB first.
// Both cores work on unsigned magnitudes. FIXUP applies the sign and selects the result.
// Handshake: a request is taken on a rising edge with valid_i && ready_o && !flush_i.
// The result is presented with valid_o and held stable until valid_o && ready_i at an edge.
// flush_i overrides both handshakes and returns the unit to IDLE.
module ysyx_24080006_mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      mdu_op_i,
    input  logic            signed_a_i,
    input  logic            signed_b_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {MDU_MULL = 2'd0, MDU_MULH = 2'd1, MDU_DIV = 2'd2, MDU_REM = 2'd3} mdu_op_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_e;

    localparam int N_MUL = XLEN / MUL_STEP;
    localparam int N_DIV = XLEN / DIV_STEP;
    localparam int N_MAX = (N_MUL > N_DIV) ? N_MUL : N_DIV;
    localparam int CW    = $clog2(N_MAX + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    if (XLEN % MUL_STEP != 0) begin : g_bad_mul_step
        $error("XLEN must be a multiple of MUL_STEP");
    end
    if (XLEN % DIV_STEP != 0) begin : g_bad_div_step
        $error("XLEN must be a multiple of DIV_STEP");
    end

    state_e              r_state, w_state_next;
    mdu_op_e             r_op;
    logic                r_neg_a, r_neg_b;
    logic [XLEN-1:0]     r_opnd;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_acc;       // mul: {partial hi, multiplier/product lo}; div: {remainder, dividend/quotient}
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_accept, w_is_div, w_div_zero, w_div_ovf, w_special;
    logic                w_neg_a, w_neg_b;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res;
    logic [CW-1:0]       w_last_cnt;
    logic [XLEN+MUL_STEP-1:0] w_pp, w_sum;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix;

    assign w_accept   = valid_i & ready_o & ~flush_i;
    assign w_is_div   = mdu_op_i[1];
    assign w_div_zero = w_is_div & (b_i == '0);
    assign w_div_ovf  = w_is_div & signed_a_i & signed_b_i & (a_i == MIN_INT) & (b_i == '1);
    assign w_special  = w_div_zero | w_div_ovf;
    assign w_neg_a    = signed_a_i & a_i[XLEN-1];
    assign w_neg_b    = signed_b_i & b_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? (~a_i + 1'b1) : a_i;
    assign w_mag_b    = w_neg_b ? (~b_i + 1'b1) : b_i;
    assign w_last_cnt = r_op[1] ? CW'(N_DIV - 1) : CW'(N_MUL - 1);

    // Early result for divide-by-zero and signed overflow.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = (mdu_op_i == MDU_DIV) ? '1 : a_i;
        end else begin
            w_special_res = (mdu_op_i == MDU_DIV) ? MIN_INT : '0;
        end
    end

    // One shift-add step: add multiplicand * low digit into the high half, shift right.
    always_comb begin
        w_pp       = {{MUL_STEP{1'b0}}, r_opnd} * {{XLEN{1'b0}}, r_acc[MUL_STEP-1:0]};
        w_sum      = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
        w_mul_next = {w_sum, r_acc[XLEN-1:MUL_STEP]};
    end

    // DIV_STEP restoring trial subtractions, dividend bits shifted in MSB first.
    always_comb begin
        logic [XLEN:0]   t_rem;
        logic [XLEN-1:0] t_quo;
        t_rem = {1'b0, r_acc[2*XLEN-1:XLEN]};
        t_quo = r_acc[XLEN-1:0];
        for (int i = 0; i < DIV_STEP; i++) begin
            t_rem = {t_rem[XLEN-1:0], t_quo[XLEN-1]};
            t_quo = {t_quo[XLEN-2:0], 1'b0};
            if (t_rem >= {1'b0, r_opnd}) begin
                t_rem    = t_rem - {1'b0, r_opnd};
                t_quo[0] = 1'b1;
            end
        end
        w_div_next = {t_rem[XLEN-1:0], t_quo};
    end

    // Sign correction and result selection applied in FIXUP.
    always_comb begin
        w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
        w_quo  = (r_neg_a ^ r_neg_b) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem  = r_neg_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        case (r_op)
            MDU_MULL: w_fix = w_prod[XLEN-1:0];
            MDU_MULH: w_fix = w_prod[2*XLEN-1:XLEN];
            MDU_DIV:  w_fix = w_quo;
            default:  w_fix = w_rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == w_last_cnt) w_state_next = S_FIXUP;
            S_FIXUP: w_state_next = S_DONE;
            S_DONE:  if (ready_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush_i) w_state_next = S_IDLE;
    end

    // Datapath: latch operands on accept, iterate in CALC, register the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= MDU_MULL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= mdu_op_e'(mdu_op_i);
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_cnt   <= '0;
                        if (w_is_div) begin
                            r_opnd <= w_mag_b;
                            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                        end else begin
                            r_opnd <= w_mag_a;
                            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                        end
                        if (w_special) r_result <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIXUP: r_result <= w_fix;
                default: ;
            endcase
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign valid_o     = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign result_o    = r_result;
    assign dbg_state_o = r_state;

endmodule
